// File: rtl/nibble_sweep_checker_pkg.sv
// Shared definitions for the nibble sweep checker.
// Contents: FSM state encoding (one-hot, 3 bits), code/error/dwell widths,
// the last stimulus code, and a truth-table lookup helper.
package nibble_sweep_pkg;

    localparam int CODE_W  = 4;
    localparam int ERR_W   = 5;   // holds 0..16 mismatching codes
    localparam int DWELL_W = 8;   // dwell lengths up to 255 cycles

    localparam logic [CODE_W-1:0] LAST_CODE = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'b001,
        ST_DRIVE = 3'b010,
        ST_DONE  = 3'b100
    } state_t;

    // Bit 'code' of a 16-entry truth table is the expected LED level for that code.
    function automatic logic exp_bit(input logic [15:0] tt, input logic [CODE_W-1:0] code);
        return tt[code];
    endfunction

endpackage

// File: rtl/nibble_sweep_checker_if.sv
// Bus between the sweep checker and whatever drives/observes it.
// Signals:
//   start            request a sweep (single-cycle pulse)
//   led1_in/led2_in  responses of the logic under test
//   a_out            stimulus code
//   busy, done, pass sweep status
//   err_count        mismatching codes in the last sweep
//   first_fail_code  first mismatching code, first_fail_valid flags it
//   fsm_state, dwell debug view of the FSM state and dwell counter
//
// Handshake: start is sampled on the rising clock edge and is accepted only
// when the checker is idle or when done=1; an accepted start raises busy on
// the next cycle. While busy=1, or in the cycle between busy falling and done
// rising, start is ignored. done stays high until the next accepted start.
interface nibble_sweep_if;
    import nibble_sweep_pkg::*;

    logic                start;
    logic                led1_in;
    logic                led2_in;
    logic [CODE_W-1:0]   a_out;
    logic                busy;
    logic                done;
    logic                pass;
    logic [ERR_W-1:0]    err_count;
    logic [CODE_W-1:0]   first_fail_code;
    logic                first_fail_valid;
    logic [2:0]          fsm_state;
    logic [DWELL_W-1:0]  dwell;

    modport master (
        output start, led1_in, led2_in,
        input  a_out, busy, done, pass, err_count, first_fail_code,
               first_fail_valid, fsm_state, dwell
    );

    modport slave (
        input  start, led1_in, led2_in,
        output a_out, busy, done, pass, err_count, first_fail_code,
               first_fail_valid, fsm_state, dwell
    );

endinterface

// File: rtl/nibble_sweep_checker_dwell_timer.sv
// Dwell timer: counts 0..DWELL_CYCLES-1 for each stimulus code.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   clear         restart the count at 0 (has priority over en)
//   en            advance the count
//   count         current dwell position
//   sample_pulse  count==SETTLE_CYCLES while enabled: LEDs are settled
//   wrap_pulse    count==DWELL_CYCLES-1 while enabled: last cycle of the code
module sweep_dwell_timer
    import nibble_sweep_pkg::*;
#(
    parameter int DWELL_CYCLES  = 10,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               en,
    output logic [DWELL_W-1:0] count,
    output logic               sample_pulse,
    output logic               wrap_pulse
);

    localparam logic [DWELL_W-1:0] SETTLE_V = DWELL_W'(SETTLE_CYCLES);
    localparam logic [DWELL_W-1:0] LAST_V   = DWELL_W'(DWELL_CYCLES - 1);

    assign sample_pulse = en && !clear && (count == SETTLE_V);
    assign wrap_pulse   = en && !clear && (count == LAST_V);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en) begin
            count <= wrap_pulse ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/nibble_sweep_checker.sv
// On-chip sweep engine for a 4-input / 2-LED combinational block.
// Drives codes 0..15 on a_out, holding each for DWELL_CYCLES, samples both
// LED responses SETTLE_CYCLES after each code change, compares them with the
// EXP_LED1/EXP_LED2 truth tables, counts mismatching codes and latches the
// first failing code.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    nibble_sweep_if slave: start, led1_in, led2_in in; a_out, busy,
//          done, pass, err_count, first_fail_code, first_fail_valid,
//          fsm_state, dwell out. All outputs are registered.
module nibble_sweep_checker
    import nibble_sweep_pkg::*;
#(
    parameter int          DWELL_CYCLES  = 10,
    parameter int          SETTLE_CYCLES = 2,
    parameter logic [15:0] EXP_LED1      = 16'h8000,
    parameter logic [15:0] EXP_LED2      = 16'hFFFE
) (
    input  logic          clk,
    input  logic          rst_n,
    nibble_sweep_if.slave bus
);

    state_t              state_q, state_d;
    logic                accept;
    logic                timer_en;
    logic                sample;
    logic                wrap;
    logic                last_code;
    logic                mismatch;
    logic [DWELL_W-1:0]  dwell;

    logic [CODE_W-1:0]   a_q;
    logic                busy_q;
    logic                done_q;
    logic                pass_q;
    logic [ERR_W-1:0]    err_q;
    logic [CODE_W-1:0]   ffc_q;
    logic                ffv_q;

    sweep_dwell_timer #(
        .DWELL_CYCLES  (DWELL_CYCLES),
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_timer (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (accept),
        .en           (timer_en),
        .count        (dwell),
        .sample_pulse (sample),
        .wrap_pulse   (wrap)
    );

    assign last_code = (a_q == LAST_CODE);

    // A code counts once even if both LEDs are wrong.
    assign mismatch = sample &&
                      ((bus.led1_in != exp_bit(EXP_LED1, a_q)) ||
                       (bus.led2_in != exp_bit(EXP_LED2, a_q)));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept) state_d = ST_DRIVE;
            ST_DRIVE: if (wrap && last_code) state_d = ST_DONE;
            ST_DONE:  if (accept) state_d = ST_DRIVE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // FSM control outputs. In DONE a restart is taken only once done is
    // visible, so a start coinciding with the DONE entry edge (or the edge
    // right after it) is dropped.
    always_comb begin
        accept   = 1'b0;
        timer_en = 1'b0;
        case (state_q)
            ST_IDLE:  accept   = bus.start;
            ST_DRIVE: timer_en = 1'b1;
            ST_DONE:  accept   = bus.start && done_q;
            default:  accept   = 1'b0;
        endcase
    end

    // Code counter and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            pass_q <= 1'b0;
            err_q  <= '0;
            ffc_q  <= '0;
            ffv_q  <= 1'b0;
        end else if (accept) begin
            a_q    <= '0;
            busy_q <= 1'b1;
            done_q <= 1'b0;
            pass_q <= 1'b0;
            err_q  <= '0;
            ffc_q  <= '0;
            ffv_q  <= 1'b0;
        end else begin
            if (mismatch) begin
                err_q <= err_q + 1'b1;
                if (!ffv_q) begin
                    ffc_q <= a_q;
                    ffv_q <= 1'b1;
                end
            end
            if ((state_q == ST_DRIVE) && wrap) begin
                if (last_code) begin
                    a_q    <= '0;
                    busy_q <= 1'b0;
                end else begin
                    a_q <= a_q + 1'b1;
                end
            end
            // err_q is final by the time DONE is entered, so the verdict
            // is taken from the register one edge later.
            if ((state_q == ST_DONE) && !done_q) begin
                done_q <= 1'b1;
                pass_q <= (err_q == '0);
            end
        end
    end

    assign bus.a_out            = a_q;
    assign bus.busy             = busy_q;
    assign bus.done             = done_q;
    assign bus.pass             = pass_q;
    assign bus.err_count        = err_q;
    assign bus.first_fail_code  = ffc_q;
    assign bus.first_fail_valid = ffv_q;
    assign bus.fsm_state        = state_q;
    assign bus.dwell            = dwell;

endmodule
